// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one byte-wide single-ported memory between the instruction-fetch
// port and the data load/store port. Each 32-bit access is sequenced as four
// byte cycles, big-endian (lowest address carries bits [31:24]).
//
// Configuration macro: ARB_RR_EN
//   undefined -> fixed priority, data wins over fetch on contention
//   defined   -> round-robin, the port not granted last wins on contention
//
// Handshake: a requester raises *_req and holds it (with its address/data
// stable) until it sees its one-cycle *_ack. Requests are only sampled in
// IDLE; a request still high after its ack is served again as a new access.
module mem_port_arbiter #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        ACK  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;

    logic              any_req;
    logic              grant_data;      // 1 = data port wins this IDLE edge
    logic [31:0]       sel_addr;

    logic              gnt_data_q;      // port owning the current access
    logic              we_q;
    logic [ADDR_W-1:0] base_q;
    logic [31:0]       wdata_q;
    logic [23:0]       asm_q;           // first three bytes of a read
    logic [31:0]       if_rdata_q;
    logic [31:0]       d_rdata_q;

    logic              unused_addr_bits;

    assign any_req  = if_req | d_req;
    assign sel_addr = grant_data ? d_addr : if_addr;

    // Bits above the memory width and the byte offset are dropped on purpose.
    assign unused_addr_bits = ^{sel_addr[31:ADDR_W], sel_addr[1:0]};

`ifdef ARB_RR_EN
    logic last_data_q;                  // 0 = fetch granted last, 1 = data

    // Round-robin: on contention favour the port not granted last time;
    // a lone requester is always granted.
    always_comb begin
        if (if_req && d_req) grant_data = ~last_data_q;
        else                 grant_data = d_req;
    end

    // Record the winner of every grant.
    always_ff @(posedge clk) begin
        if (rst)                             last_data_q <= 1'b0;
        else if (state_q == IDLE && any_req) last_data_q <= grant_data;
    end
`else
    // Fixed priority: data always beats fetch.
    assign grant_data = d_req;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: IDLE -> XFER (4 byte cycles) -> ACK -> IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = 2'd0;
        case (state_q)
            IDLE: begin
                if (any_req) state_d = XFER;
            end
            XFER: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) state_d = ACK;
            end
            ACK: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the current state.
    always_comb begin
        busy      = 1'b0;
        if_ack    = 1'b0;
        d_ack     = 1'b0;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = 8'h00;
        case (state_q)
            XFER: begin
                busy     = 1'b1;
                mem_addr = base_q + {{(ADDR_W-2){1'b0}}, cnt_q};
                if (we_q) begin
                    // Reset wins over the byte in flight so an aborted store
                    // leaves the current byte untouched.
                    mem_we = ~rst;
                    case (cnt_q)
                        2'd0:    mem_wdata = wdata_q[31:24];
                        2'd1:    mem_wdata = wdata_q[23:16];
                        2'd2:    mem_wdata = wdata_q[15:8];
                        default: mem_wdata = wdata_q[7:0];
                    endcase
                end
            end
            ACK: begin
                busy   = 1'b1;
                if_ack = ~gnt_data_q;
                d_ack  = gnt_data_q;
            end
            default: ;
        endcase
    end

    // Request capture at grant, byte assembly during XFER, result update on
    // the last byte so read data is valid in the ACK cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_data_q <= 1'b0;
            we_q       <= 1'b0;
            base_q     <= '0;
            wdata_q    <= 32'h0;
            asm_q      <= 24'h0;
            if_rdata_q <= 32'h0;
            d_rdata_q  <= 32'h0;
        end else begin
            if (state_q == IDLE && any_req) begin
                gnt_data_q <= grant_data;
                we_q       <= grant_data & d_we;
                base_q     <= {sel_addr[ADDR_W-1:2], 2'b00};
                wdata_q    <= d_wdata;
            end
            if (state_q == XFER) begin
                asm_q <= {asm_q[15:0], mem_rdata};
                if (cnt_q == 2'd3 && !we_q) begin
                    if (gnt_data_q) d_rdata_q  <= {asm_q, mem_rdata};
                    else            if_rdata_q <= {asm_q, mem_rdata};
                end
            end
        end
    end

    assign if_rdata = if_rdata_q;
    assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: byte memory model, directed scenarios,
// randomized request rounds, and a word-level reference model.
module tb_mem_port_arbiter;
  localparam int ADDR_W = 16;
  localparam int MEM_N  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req;
  logic [31:0]       if_addr;
  logic [31:0]       if_rdata;
  logic              if_ack;
  logic              d_req;
  logic              d_we;
  logic [31:0]       d_addr;
  logic [31:0]       d_wdata;
  logic [31:0]       d_rdata;
  logic              d_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              busy;

  mem_port_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // clock
  always #5 clk = ~clk;

  // byte memory attached to the DUT (combinational read, write on edge)
  logic [7:0] mem_arr [MEM_N];
  assign mem_rdata = mem_arr[mem_addr];
  always @(posedge clk) if (mem_we) mem_arr[mem_addr] = mem_wdata;

  // reference model state
  logic [7:0]  ref_mem [MEM_N];
  logic [31:0] exp_q[$];
  int          port_q[$];
  logic [31:0] exp_if_rdata;
  logic [31:0] exp_d_rdata;
  int          last_port;      // 0 = fetch, 1 = data

  logic [ADDR_W-1:0] addr_log[$];
  logic              we_log[$];

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] base_of(input logic [31:0] a);
    return ((a / 4) * 4) % MEM_N;
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] b);
    return {ref_mem[b], ref_mem[b+1], ref_mem[b+2], ref_mem[b+3]};
  endfunction

  // who wins when the given ports request together
  function automatic int pick(input bit i_on, input bit d_on);
`ifdef ARB_RR_EN
    if (i_on && d_on) return (last_port == 0) ? 1 : 0;
`endif
    return d_on ? 1 : 0;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom();
    if ($urandom_range(0, 1) == 1)
      a = (a & 32'hFFFF_0003) | (32'h300 + 4 * $urandom_range(0, 15));
    return a;
  endfunction

  task automatic preload(input int a, input logic [7:0] b);
    mem_arr[a] = b;
    ref_mem[a] = b;
  endtask

  // model one access in service order: apply stores, queue expected result
  task automatic model_serve(input int port);
    logic [31:0] b;
    if (port == 1) begin
      b = base_of(d_addr);
      if (d_we) begin
        for (int i = 0; i < 4; i++) ref_mem[b+i] = d_wdata[31-8*i -: 8];
        exp_q.push_back(exp_d_rdata);
      end else begin
        exp_q.push_back(word_at(b));
      end
    end else begin
      exp_q.push_back(word_at(base_of(if_addr)));
    end
    port_q.push_back(port);
  endtask

  // wait (bounded) for an ack, logging the memory cycles on the way
  task automatic wait_ack(output int got, output int edges);
    got   = -1;
    edges = 0;
    addr_log.delete();
    we_log.delete();
    for (int k = 0; k < 20 && got < 0; k++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (if_ack && d_ack) got = 3;
      else if (d_ack)      got = 1;
      else if (if_ack)     got = 0;
      else if (busy) begin
        addr_log.push_back(mem_addr);
        we_log.push_back(mem_we);
      end
    end
  endtask

  task automatic expect_access(input int exp_lat);
    int          got;
    int          edges;
    int          port;
    logic [31:0] data;
    logic [31:0] b;
    logic        we;
    wait_ack(got, edges);
    port = port_q.pop_front();
    data = exp_q.pop_front();
    b    = (port == 1) ? base_of(d_addr) : base_of(if_addr);
    we   = (port == 1) && d_we;
    check_eq("ack_port", got, port);
    check_eq("latency", edges, exp_lat);
    check_eq("xfer_cycles", addr_log.size(), 4);
    for (int i = 0; i < addr_log.size(); i++) begin
      check_eq("mem_addr", addr_log[i], (b + i) % MEM_N);
      check_eq("mem_we", we_log[i], we);
    end
    check_eq("ack_mem_addr", mem_addr, 0);
    check_eq("ack_mem_we", mem_we, 0);
    if (port == 1) exp_d_rdata = data;
    else           exp_if_rdata = data;
    check_eq("if_rdata", if_rdata, exp_if_rdata);
    check_eq("d_rdata", d_rdata, exp_d_rdata);
    if (we)
      for (int i = 0; i < 4; i++) check_eq("mem_byte", mem_arr[b+i], d_wdata[31-8*i -: 8]);
  endtask

  task automatic check_idle();
    check_eq("idle_busy", busy, 0);
    check_eq("idle_if_ack", if_ack, 0);
    check_eq("idle_d_ack", d_ack, 0);
    check_eq("idle_mem_we", mem_we, 0);
    check_eq("idle_mem_addr", mem_addr, 0);
  endtask

  // one round: requests raised together, each dropped right after its ack
  task automatic run_round(input bit i_on, input bit d_on, input logic [31:0] ia,
                           input logic [31:0] da, input bit we, input logic [31:0] wd);
    int first;
    if_req  = i_on;
    if_addr = ia;
    d_req   = d_on;
    d_we    = we;
    d_addr  = da;
    d_wdata = wd;
    first = pick(i_on, d_on);
    last_port = first;
    model_serve(first);
    if (i_on && d_on) begin
      last_port = 1 - first;
      model_serve(1 - first);
    end
    expect_access(5);
    if (first == 1) d_req = 1'b0;
    else            if_req = 1'b0;
    if (i_on && d_on) begin
      expect_access(6);
      if_req = 1'b0;
      d_req  = 1'b0;
    end
    @(negedge clk);
    check_idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int   quiet_acks;
    logic [7:0] b;
    // reset
    rst = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0;
    exp_if_rdata = 32'h0; exp_d_rdata = 32'h0; last_port = 0;
    for (int a = 0; a < MEM_N; a++) begin
      b = 8'($urandom());
      mem_arr[a] = b;
      ref_mem[a] = b;
    end
    repeat (3) @(negedge clk);
    check_eq("rst_if_rdata", if_rdata, 0);
    check_eq("rst_d_rdata", d_rdata, 0);
    check_eq("rst_mem_wdata", mem_wdata, 0);
    check_idle();
    rst = 1'b0;
    @(negedge clk);

    // fetch from an unaligned address
    preload(32'h100, 8'h12); preload(32'h101, 8'h34);
    preload(32'h102, 8'h56); preload(32'h103, 8'h78);
    run_round(1, 0, 32'h102, 32'h0, 0, 32'h0);
    check_eq("fetch_word", if_rdata, 32'h12345678);

    // store then load back
    run_round(0, 1, 32'h0, 32'h200, 1, 32'hDEADBEEF);
    run_round(0, 1, 32'h0, 32'h200, 0, 32'h0);
    check_eq("load_word", d_rdata, 32'hDEADBEEF);

    // simultaneous requests, then store beating a fetch of the same word
    run_round(1, 1, 32'h100, 32'h200, 0, 32'h0);
    run_round(1, 1, 32'h200, 32'h200, 1, 32'hCAFEF00D);

    // both held high through three acks
    if_req = 1'b1; if_addr = 32'h100;
    d_req  = 1'b1; d_addr  = 32'h200; d_we = 1'b0;
    for (int r = 0; r < 3; r++) begin
      int p;
      p = pick(1, 1);
      last_port = p;
      model_serve(p);
      expect_access(r == 0 ? 5 : 6);
    end
    if_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    check_idle();

    // top-of-memory and truncated addresses
    run_round(0, 1, 32'h0, 32'h0000_FFFC, 0, 32'h0);
    run_round(0, 1, 32'h0, 32'h0001_0000, 0, 32'h0);
    run_round(1, 0, 32'hABCD_FFFF, 32'h0, 0, 32'h0);

    // randomized rounds
    for (int r = 0; r < 40; r++) begin
      bit i_on;
      bit d_on;
      do begin
        i_on = 1'($urandom_range(0, 1));
        d_on = 1'($urandom_range(0, 1));
      end while (!i_on && !d_on);
      run_round(i_on, d_on, rand_addr(), rand_addr(), 1'($urandom_range(0, 1)), $urandom());
    end

    // reset in the middle of a store
    preload(32'h40, 8'h11); preload(32'h41, 8'h22);
    preload(32'h42, 8'h33); preload(32'h43, 8'h44);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hA1B2C3D4;
    repeat (3) @(negedge clk);
    check_eq("mid_store_addr", mem_addr, 32'h42);
    rst = 1'b1;
    d_req = 1'b0;
    @(negedge clk);
    check_eq("rst_if_rdata2", if_rdata, 0);
    check_eq("rst_d_rdata2", d_rdata, 0);
    check_eq("rst_mem_wdata2", mem_wdata, 0);
    check_idle();
    rst = 1'b0;
    quiet_acks = 0;
    repeat (8) begin
      @(negedge clk);
      if (if_ack || d_ack || busy) quiet_acks++;
    end
    check_eq("no_ack_after_rst", quiet_acks, 0);
    check_eq("rst_byte40", mem_arr[32'h40], 8'hA1);
    check_eq("rst_byte41", mem_arr[32'h41], 8'hB2);
    check_eq("rst_byte42", mem_arr[32'h42], 8'h33);
    check_eq("rst_byte43", mem_arr[32'h43], 8'h44);
    ref_mem[32'h40] = 8'hA1;
    ref_mem[32'h41] = 8'hB2;
    exp_if_rdata = 32'h0; exp_d_rdata = 32'h0; last_port = 0;

    // service resumes normally after the abort
    run_round(1, 1, 32'h40, 32'h40, 0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
